// File: rtl/cq_enq_arbiter.sv
// Round-robin enqueue arbiter and flush sequencer for one circular_q instance.
// Tracks occupancy locally and exposes the queue head as a valid/ready stream.
module cq_enq_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         gnt,
  output logic                 q_enq,
  output logic [WIDTH-1:0]     q_in,
  output logic                 q_deq,
  input  logic                 q_empty,
  input  logic                 q_full,
  input  logic [WIDTH-1:0]     q_out,
  output logic                 cons_valid,
  input  logic                 cons_ready,
  output logic [WIDTH-1:0]     cons_data,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic [CW-1:0]        count
);

  // state | meaning
  // RUN   | arbitrate enqueues, stream head to consumer
  // FLUSH | discard one entry per cycle until occupancy reaches zero
  typedef enum logic {RUN, FLUSH} state_t;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   count_nxt;
  logic            found;
  logic            room;
  logic            run_ok;
  int              idx;

  // Outputs are forced quiet while rst is high so the reset values hold without a clock.
  assign run_ok = (state == RUN) && !rst;
  assign room   = !q_full && (count != CW'(DEPTH));

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt    = '0;
    q_in   = '0;
    rr_nxt = rr_ptr;
    if (run_ok && room && found) begin
      gnt[gidx] = 1'b1;
      q_in      = req_data[int'(gidx)*WIDTH +: WIDTH];
      rr_nxt    = (int'(gidx) == N-1) ? '0 : gidx + 1'b1;
    end
  end

  assign q_enq     = |gnt;
  assign cons_data = q_out;

  always_comb begin
    state_nxt  = state;
    cons_valid = 1'b0;
    q_deq      = 1'b0;
    flush_busy = 1'b0;
    case (state)
      RUN: begin
        cons_valid = run_ok && !q_empty;
        q_deq      = cons_valid && cons_ready;
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_busy = !rst;
        q_deq      = !rst && !q_empty;
        if (count == '0 || (count == CW'(1) && q_deq)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (q_enq && !q_deq && count != CW'(DEPTH))
      count_nxt = count + 1'b1;
    else if (!q_enq && q_deq && count != '0)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_cq_enq_arbiter.sv
// Bench for cq_enq_arbiter with a behavioural circular_q attached to its queue pins.
module tb_cq_enq_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 8;
  localparam int CW = $clog2(D+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic             q_enq, q_deq, q_empty, q_full;
  logic [W-1:0]     q_in, q_out;
  logic             cons_valid, cons_ready;
  logic [W-1:0]     cons_data;
  logic             flush, flush_busy;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  cq_enq_arbiter #(.N(N), .WIDTH(W), .DEPTH(D), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .q_enq(q_enq), .q_in(q_in), .q_deq(q_deq), .q_empty(q_empty),
    .q_full(q_full), .q_out(q_out), .cons_valid(cons_valid),
    .cons_ready(cons_ready), .cons_data(cons_data), .flush(flush),
    .flush_busy(flush_busy), .count(count)
  );

  // behavioural circular_q
  logic [W-1:0] mem [D];
  int wp, rp, sz;
  assign q_empty = (sz == 0);
  assign q_full  = (sz == D);
  assign q_out   = mem[rp];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= 0; rp <= 0; sz <= 0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (q_enq && sz < D) begin
        mem[wp] <= q_in;
        wp <= (wp + 1) % D;
      end
      if (q_deq && sz > 0) rp <= (rp + 1) % D;
      sz <= sz + ((q_enq && sz < D) ? 1 : 0) - ((q_deq && sz > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = base + W'(i);
  endtask

  // monitor: every accepted head must match the oldest expected entry
  always begin
    @(negedge clk);
    #2;
    if (!rst && cons_valid && cons_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow actual=%0h required=none", cons_data);
      end else begin
        chk("cons_data", 64'(cons_data), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; flush = 1'b0; cons_ready = 1'b0;
    set_data(32'h10);
    #2;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_busy", 64'(flush_busy), 0);
    chk("rst_valid", 64'(cons_valid), 0);
    chk("rst_enq", 64'(q_enq), 0);
    chk("rst_deq", 64'(q_deq), 0);
    @(negedge clk); rst = 1'b0;

    repeat (2) begin
      @(negedge clk); #1;
      chk("idle_gnt", 64'(gnt), 0);
    end

    // round-robin fill with cons_ready low
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); req = 4'hF; #1;
      chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
      chk("rr_count", 64'(count), 64'(k));
      sb.push_back(32'h10 + 32'(k % 4));
    end
    @(negedge clk); #1;
    chk("full_gnt", 64'(gnt), 0);
    chk("full_count", 64'(count), 8);

    // full boundary: dequeue first, grant only on the following cycle
    @(negedge clk); req = 4'b0100; cons_ready = 1'b1; #1;
    chk("fb_gnt0", 64'(gnt), 0);
    chk("fb_deq0", 64'(q_deq), 1);
    chk("fb_count0", 64'(count), 8);
    @(negedge clk); #1;
    chk("fb_gnt1", 64'(gnt), 64'(4'b0100));
    chk("fb_count1", 64'(count), 7);
    sb.push_back(32'h12);
    @(negedge clk); req = '0; cons_ready = 1'b0; #1;
    chk("fb_count2", 64'(count), 7);

    for (int j = 0; j < 4; j++) begin
      @(negedge clk); cons_ready = 1'b1; #1;
      chk("drain_count", 64'(count), 64'(7 - j));
    end

    // simultaneous enqueue and dequeue at count 3
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); req = 4'b0001; req_data[0 +: W] = 32'h20 + 32'(k); cons_ready = 1'b1; #1;
      chk("sim_gnt", 64'(gnt), 1);
      chk("sim_count", 64'(count), 3);
      sb.push_back(32'h20 + 32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); cons_ready = 1'b0; req = 4'b0001; req_data[0 +: W] = 32'h30 + 32'(k); #1;
      chk("fill_gnt", 64'(gnt), 1);
      chk("fill_count", 64'(count), 64'(3 + k));
      sb.push_back(32'h30 + 32'(k));
    end

    // flush of 5 entries; a second pulse inside FLUSH is ignored
    @(negedge clk); req = '0; flush = 1'b1; set_data(32'h10); #1;
    chk("fl_busy_pulse", 64'(flush_busy), 0);
    chk("fl_count_pulse", 64'(count), 5);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); flush = (j == 2); req = 4'hF; #1;
      if (j == 0) sb.delete();
      chk("fl_busy", 64'(flush_busy), 1);
      chk("fl_gnt", 64'(gnt), 0);
      chk("fl_valid", 64'(cons_valid), 0);
      chk("fl_deq", 64'(q_deq), 1);
      chk("fl_count", 64'(count), 64'(5 - j));
    end
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_exit_busy", 64'(flush_busy), 0);
    chk("fl_exit_count", 64'(count), 0);
    chk("fl_rr_gnt", 64'(gnt), 64'(4'b0010));
    sb.push_back(32'h11);
    @(negedge clk); req = '0; cons_ready = 1'b1; #1;
    chk("post_valid", 64'(cons_valid), 1);
    chk("post_count", 64'(count), 1);

    // empty flush
    @(negedge clk); cons_ready = 1'b0; flush = 1'b1; #1;
    chk("ef_count", 64'(count), 0);
    chk("ef_busy0", 64'(flush_busy), 0);
    @(negedge clk); flush = 1'b0; #1;
    chk("ef_busy1", 64'(flush_busy), 1);
    chk("ef_deq", 64'(q_deq), 0);
    @(negedge clk); #1;
    chk("ef_busy2", 64'(flush_busy), 0);
    chk("sb_empty", 64'(sb.size()), 0);

    // reset mid-traffic, no clock edge in between
    repeat (2) begin
      @(negedge clk); req = 4'hF;
    end
    @(negedge clk); #3; rst = 1'b1; #1;
    chk("mr_gnt", 64'(gnt), 0);
    chk("mr_enq", 64'(q_enq), 0);
    chk("mr_deq", 64'(q_deq), 0);
    chk("mr_valid", 64'(cons_valid), 0);
    chk("mr_count", 64'(count), 0);
    chk("mr_busy", 64'(flush_busy), 0);
    @(negedge clk); req = '0; rst = 1'b0; #1;
    chk("mr_idle_gnt", 64'(gnt), 0);
    @(negedge clk); #1;
    chk("mr_idle_gnt2", 64'(gnt), 0);
    @(negedge clk); req = 4'hF; #1;
    chk("mr_first_gnt", 64'(gnt), 1);
    @(negedge clk); req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
